// File: rtl/d7s_pkg.sv
// rtl/d7s_pkg.sv - shared types, constants and helpers for the 7-seg display blocks
package d7s_pkg;

    typedef logic [3:0] nibble_t;

    localparam logic DIG_OFF    = 1'b1;
    localparam int   MAX_DIGITS = 16;

    // True when digit i (i>0) and every digit above it are zero; digit 0 never qualifies.
    function automatic logic is_lead_zero(input logic [4*MAX_DIGITS-1:0] disp, input int i);
        logic z;
        z = (i != 0);
        for (int j = 0; j < MAX_DIGITS; j++) begin
            if (j >= i && disp[4*j +: 4] != 4'h0) z = 1'b0;
        end
        return z;
    endfunction

endpackage

// File: rtl/d7s_scan_if.sv
// rtl/d7s_scan_if.sv - value load and scanned display outputs of d7s_scan
interface d7s_scan_if #(parameter int N_DIGITS = 4);
    import d7s_pkg::*;

    logic                  load;
    logic [4*N_DIGITS-1:0] value;
    logic                  pending;
    nibble_t               nib;
    logic                  nib_en;
    logic [N_DIGITS-1:0]   dig;

    modport master (output load, value, input pending, nib, nib_en, dig);
    modport slave  (input load, value, output pending, nib, nib_en, dig);

endinterface

// File: rtl/d7s_tick.sv
// rtl/d7s_tick.sv - digit-slot prescaler: cnt runs 0..PRESCALE-1, tick on the last count
module d7s_tick #(
    parameter int  PRESCALE = 50000,
    localparam int CW       = $clog2(PRESCALE)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [CW-1:0] cnt,
    output logic          tick
);

    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else     cnt <= tick ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/d7s_scan.sv
// rtl/d7s_scan.sv - multiplexed 7-seg scanner with frame-synchronous update and slot blanking
// Optional LEADING_ZERO_BLANK_EN: suppress nib_en on leading zero digits above digit 0.
module d7s_scan
    import d7s_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 2
) (
    input  logic      clk,
    input  logic      rst,
    d7s_scan_if.slave bus
);

    localparam int CW  = $clog2(PRESCALE);
    localparam int IW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int W   = 4 * N_DIGITS;
    localparam int LZW = 4 * MAX_DIGITS;

    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    logic [CW-1:0]       cnt;
    logic                tick;
    logic                frame_wrap;
    logic [IW-1:0]       idx;
    logic [W-1:0]        shadow;
    logic [W-1:0]        disp;
    logic                pending_r;
    logic [N_DIGITS-1:0] dig_r, dig_n;
    nibble_t             nib_r, nib_n;
    logic                nib_en_r, nib_en_n;

    d7s_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .tick (tick)
    );

    assign frame_wrap = tick && (idx == IDX_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       idx <= '0;
        else if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end

    // disp only moves at the frame boundary so a frame never shows mixed digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow    <= '0;
            disp      <= '0;
            pending_r <= 1'b0;
        end else if (frame_wrap && bus.load) begin
            shadow    <= bus.value;
            disp      <= bus.value;
            pending_r <= 1'b0;
        end else if (frame_wrap && pending_r) begin
            disp      <= shadow;
            pending_r <= 1'b0;
        end else if (bus.load) begin
            shadow    <= bus.value;
            pending_r <= 1'b1;
        end
    end

    always_comb begin
        dig_n    = {N_DIGITS{DIG_OFF}};
        nib_n    = disp[{idx, 2'b00} +: 4];
        nib_en_n = 1'b0;
        if (cnt >= BLANK_C) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                if (idx == IW'(i)) dig_n[i] = ~DIG_OFF;
            end
            nib_en_n = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            if (is_lead_zero(LZW'(disp), int'(idx))) nib_en_n = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dig_r    <= {N_DIGITS{DIG_OFF}};
            nib_r    <= '0;
            nib_en_r <= 1'b0;
        end else begin
            dig_r    <= dig_n;
            nib_r    <= nib_n;
            nib_en_r <= nib_en_n;
        end
    end

    assign bus.pending = pending_r;
    assign bus.dig     = dig_r;
    assign bus.nib     = nib_r;
    assign bus.nib_en  = nib_en_r;

endmodule

// File: tb/tb_d7s_scan.sv
// tb/tb_d7s_scan.sv - scoreboard bench for d7s_scan (N_DIGITS=4, PRESCALE=8, BLANK=2)
module tb_d7s_scan;

    typedef struct packed {
        logic [3:0] dig;
        logic       en;
        logic [3:0] nib;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [2:0]  m_cnt;
    logic [1:0]  m_idx;
    logic [15:0] m_disp, m_shadow;
    logic        m_pend;
    exp_t        exp_q[$];

    d7s_scan_if #(.N_DIGITS(4)) bus ();

    d7s_scan #(.N_DIGITS(4), .PRESCALE(8), .BLANK(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic lead_zero(input logic [15:0] d, input logic [1:0] i);
`ifdef LEADING_ZERO_BLANK_EN
        return (i != 2'd0) && ((d >> (4 * i)) == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic exp_t make_exp(input logic [2:0] c, input logic [1:0] i, input logic [15:0] d);
        exp_t e;
        e.dig = (c < 3'd2) ? 4'hF : ~(4'b0001 << i);
        e.en  = (c >= 3'd2) && !lead_zero(d, i);
        e.nib = d[4*i +: 4];
        return e;
    endfunction

    // Reference model: expectation for the outputs after this edge is pushed here.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt <= '0; m_idx <= '0; m_disp <= '0; m_shadow <= '0; m_pend <= 1'b0;
            exp_q.delete();
        end else begin
            exp_q.push_back(make_exp(m_cnt, m_idx, m_disp));
            m_cnt <= m_cnt + 3'd1;
            if (m_cnt == 3'd7) m_idx <= m_idx + 2'd1;
            if (m_cnt == 3'd7 && m_idx == 2'd3 && bus.load) begin
                m_disp <= bus.value; m_shadow <= bus.value; m_pend <= 1'b0;
            end else if (m_cnt == 3'd7 && m_idx == 2'd3 && m_pend) begin
                m_disp <= m_shadow; m_pend <= 1'b0;
            end else if (bus.load) begin
                m_shadow <= bus.value; m_pend <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (!rst && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("dig", bus.dig, e.dig);
            check("nib_en", bus.nib_en, e.en);
            if (e.en) check("nib", bus.nib, e.nib);
            check("pending", bus.pending, m_pend);
        end
    end

    task automatic wait_state(input logic [1:0] i, input logic [2:0] c);
        logic found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (m_idx == i && m_cnt == c) found = 1'b1;
        end
        if (!found) check("wait_state_timeout", 0, 1);
    endtask

    task automatic load_value(input logic [15:0] v);
        bus.load  = 1'b1;
        bus.value = v;
        @(negedge clk);
        bus.load  = 1'b0;
    endtask

    initial begin
        logic seen;
        bus.load  = 1'b0;
        bus.value = 16'h0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_dig", bus.dig, 4'hF);
        check("rst_nib", bus.nib, 4'h0);
        check("rst_nib_en", bus.nib_en, 1'b0);
        check("rst_pending", bus.pending, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        load_value(16'h1234);
        repeat (64) @(negedge clk);
        wait_state(2'd0, 3'd3);
        check("t2_slot0_nib", bus.nib, 4'h4);
        check("t2_slot0_dig", bus.dig, 4'b1110);

        wait_state(2'd1, 3'd4);
        load_value(16'hABCD);
        check("t3_pending_set", bus.pending, 1'b1);
        wait_state(2'd0, 3'd3);
        check("t3_slot0_nib", bus.nib, 4'hD);
        check("t3_pending_clr", bus.pending, 1'b0);

        wait_state(2'd3, 3'd7);
        load_value(16'h5678);
        seen = 1'b0;
        for (int k = 0; k < 32; k++) begin
            if (bus.pending) seen = 1'b1;
            if (m_idx == 2'd0 && m_cnt == 3'd3) check("t4_slot0_nib", bus.nib, 4'h8);
            @(negedge clk);
        end
        check("t4_pending_never", seen, 1'b0);

        load_value(16'h0050);
        repeat (80) @(negedge clk);
        wait_state(2'd1, 3'd3);
        check("t5_slot1_nib", bus.nib, 4'h5);
        check("t5_slot1_en", bus.nib_en, 1'b1);
        wait_state(2'd2, 3'd3);
`ifdef LEADING_ZERO_BLANK_EN
        check("t5_slot2_en", bus.nib_en, 1'b0);
`else
        check("t5_slot2_en", bus.nib_en, 1'b1);
`endif
        check("t5_slot2_dig", bus.dig, 4'b1011);
        load_value(16'h0000);
        repeat (80) @(negedge clk);
        wait_state(2'd0, 3'd3);
        check("t5_zero_slot0_en", bus.nib_en, 1'b1);
        check("t5_zero_slot0_nib", bus.nib, 4'h0);
        wait_state(2'd3, 3'd3);
`ifdef LEADING_ZERO_BLANK_EN
        check("t5_zero_slot3_en", bus.nib_en, 1'b0);
`else
        check("t5_zero_slot3_en", bus.nib_en, 1'b1);
`endif

        load_value(16'h9876);
        repeat (80) @(negedge clk);
        wait_state(2'd2, 3'd5);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_dig", bus.dig, 4'hF);
        check("t6_rst_nib_en", bus.nib_en, 1'b0);
        check("t6_rst_pending", bus.pending, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t6_restart_blank", bus.dig, 4'hF);
        wait_state(2'd0, 3'd3);
        check("t6_restart_nib", bus.nib, 4'h0);
        check("t6_restart_en", bus.nib_en, 1'b1);
        check("t6_restart_dig", bus.dig, 4'b1110);
        repeat (40) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
